pcie_rst_seq: RTL and testbench
===============================

// Module: pcie_rst_seq
// PURPOSE
//  Parametrised reset sequencer for the PCIe board tops (ECP3 Versa and successors).
//  Generalises the single power-on counter into NUM_DOM ordered reset domains: PCIe core, DMA/user logic, LED/misc.
//  Adds debounced push-button reset, a software reset request and link-up gating.
//  Sits in the board top between the pins and pcie_top / pciedma; owns every reset those blocks see.
// PARAMETERS
//  NUM_DOM    3   number of reset domains; released in index order 0..NUM_DOM-1
//  CNT_W      21  POR counter width; POR delay = 2^(CNT_W-1) cycles (2^20 = 8.4 ms @125 MHz)
//  STAGE_GAP  16  cycles between successive domain releases (1..255)
//  DEB_W      16  button debounce counter width; btn_n must be stable for 2^DEB_W cycles
//  LINK_DOM   1   first domain index gated by link_up; NUM_DOM disables gating
//  HOLD_CYC   64  cycles all domains are held asserted after a button or soft reset
// PORTS
//  clk_125    in   1        125 MHz system clock from the PCIe core
//  rstn       in   1        board reset, asynchronous, active-low
//  btn_n      in   1        push-button, active-low, raw and bouncing
//  soft_rst   in   1        single-cycle soft reset request, clk_125 domain
//  link_up    in   1        PCIe data-link-up, asynchronous to clk_125
//  rst_n_out  out  NUM_DOM  per-domain reset, active-low; async assert, sync deassert
//  seq_done   out  1        every domain released and link_up high (if gated)
//  seq_state  out  3        current FSM state, for LED/debug
// BEHAVIOUR
//  - Reset: rstn low -> rst_n_out=0, seq_done=0, seq_state=S_RST, all counters 0, immediately (async).
//  - rstn deassert is synchronised by two flops; the FSM leaves S_RST 2 cycles after first clk edge with rstn high.
//  - btn_n and link_up each pass through a 2-flop synchroniser (2 cycles latency). Debounce: btn_n sync'd value
//    must be low for 2^DEB_W consecutive cycles to raise a press; a press fires once per low period.
//  - FSM states (encoding in package):
//    S_RST  -> S_POR unconditionally.
//    S_POR  : count 0..2^(CNT_W-1)-1; when cnt[CNT_W-1] sets -> S_REL, dom index k=0, gap counter 0.
//    S_REL  : release rst_n_out[k] on entry and every STAGE_GAP cycles, k++. Before releasing k>=LINK_DOM
//             with link_up low -> S_LINK. After last domain -> S_RUN.
//    S_LINK : hold; link_up high -> S_REL, release of k on the next cycle.
//    S_RUN  : seq_done=1. Press or soft_rst -> S_HOLD. link_up falls and LINK_DOM<NUM_DOM ->
//             assert rst_n_out[NUM_DOM-1:LINK_DOM] next cycle, k=LINK_DOM, -> S_LINK.
//    S_HOLD : all rst_n_out=0 from next edge for HOLD_CYC cycles, then -> S_REL with k=0 (POR not repeated).
//  - rst_n_out is a registered output; never glitches; bits released strictly in index order, never skipped.
//  - seq_done is 1 only in S_RUN; drops the cycle S_RUN is left.
//  - Simultaneous press/soft_rst and link drop in S_RUN: S_HOLD wins.
//  - soft_rst or press outside S_RUN: ignored (sequence already in progress).
//  - rstn low mid-sequence: full async reset, sequence restarts with POR.
//  - Counters saturate / clear on state entry; no wrap-around reachable.
// STRUCTURE
//  - pcie_rst_pkg: state enum S_RST,S_POR,S_REL,S_LINK,S_RUN,S_HOLD (3 bits), STAGE_GAP width constant.
//  - Sub-module rst_sync_2ff (async-clear 2-flop synchroniser), instanced for rstn, btn_n, link_up.
//  - Debounce counter, POR counter, gap counter, domain index and FSM in this module.
// TESTING  (NUM_DOM=3, CNT_W=5, STAGE_GAP=4, DEB_W=3, LINK_DOM=1, HOLD_CYC=8; t=0 first edge with rstn high)
//  1 POR, link_up=1: rst_n_out[0] rises t=18, [1] t=22, [2] t=26; seq_done=1 at t=26; state S_RUN.
//  2 link_up=0 until t=40: [0] rises t=18, [1]/[2] held in S_LINK; link_up high -> [1] rises t=43, [2] t=47.
//  3 In S_RUN pulse soft_rst: all bits 0 next cycle for 8 cycles, then 0,1,2 released 4 apart; no POR.
//  4 btn_n bounces (low 3 cycles, high 1) x5, then low steady: exactly one press after 8 stable cycles
//    (+2 sync), same hold/release as test 3; holding btn_n low gives no second press.
//  5 In S_RUN drop link_up: [2:1]=0 after 3 cycles, [0] stays 1, seq_done=0; restore -> [1],[2] re-released.
//  6 rstn low at t=20 (mid S_REL): rst_n_out=0 combinationally; release -> sequence repeats test 1 timing.

Source files
------------

// File: rtl/pcie_rst_pkg.sv
// pcie_rst_pkg: shared state encoding and counter widths for the PCIe reset sequencer
package pcie_rst_pkg;
  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_POR  = 3'd1,
    S_REL  = 3'd2,
    S_LINK = 3'd3,
    S_RUN  = 3'd4,
    S_HOLD = 3'd5
  } state_t;
  localparam int GAP_W = 8;
endpackage

// File: rtl/rst_sync_2ff.sv
// rst_sync_2ff: two-flop synchroniser with asynchronous clear to a chosen value
module rst_sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_125,
  input  logic rstn,
  input  logic d,
  output logic q
);
  logic s1;
  // shift the asynchronous input through two flops; clear both while rstn is low
  always_ff @(posedge clk_125 or negedge rstn)
    if (!rstn) {q, s1} <= {2{RST_VAL}};
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/pcie_rst_seq.sv
// pcie_rst_seq: ordered multi-domain reset release with POR delay, button/soft reset and link-up gating
module pcie_rst_seq
  import pcie_rst_pkg::*;
#(
  parameter int NUM_DOM   = 3,
  parameter int CNT_W     = 21,
  parameter int STAGE_GAP = 16,
  parameter int DEB_W     = 16,
  parameter int LINK_DOM  = 1,
  parameter int HOLD_CYC  = 64
) (
  input  logic               clk_125,
  input  logic               rstn,
  input  logic               btn_n,
  input  logic               soft_rst,
  input  logic               link_up,
  output logic [NUM_DOM-1:0] rst_n_out,
  output logic               seq_done,
  output logic [2:0]         seq_state
);
  localparam int K_W = NUM_DOM > 1 ? $clog2(NUM_DOM) : 1;
  localparam int H_W = $clog2(HOLD_CYC + 1);
  localparam logic [NUM_DOM-1:0] LOW_MASK = NUM_DOM'((64'd1 << LINK_DOM) - 64'd1);
  state_t state, state_n;
  logic [CNT_W-1:0] por_cnt, por_n;
  logic [GAP_W-1:0] gap, gap_n;
  logic [H_W-1:0] hcnt, hcnt_n;
  logic [K_W-1:0] k, k_n, rel_k;
  logic [NUM_DOM-1:0] out_r, out_n;
  logic [DEB_W-1:0] deb_cnt;
  logic rst_s, btn_s, link_s, fired, press, rel;

  rst_sync_2ff #(.RST_VAL(1'b0)) u_rst_sync (.clk_125(clk_125), .rstn(rstn), .d(1'b1), .q(rst_s));
  rst_sync_2ff #(.RST_VAL(1'b1)) u_btn_sync (.clk_125(clk_125), .rstn(rstn), .d(btn_n), .q(btn_s));
  rst_sync_2ff #(.RST_VAL(1'b0)) u_link_sync (.clk_125(clk_125), .rstn(rstn), .d(link_up), .q(link_s));

  assign press = !btn_s && !fired && &deb_cnt;
  // count consecutive low cycles of the button; one press per low period, counter parks at all-ones
  always_ff @(posedge clk_125 or negedge rstn)
    if (!rstn) begin
      deb_cnt <= '0;
      fired   <= 1'b0;
    end else if (btn_s) begin
      deb_cnt <= '0;
      fired   <= 1'b0;
    end else if (press) fired <= 1'b1;
    else if (!fired) deb_cnt <= deb_cnt + 1'b1;

  // next-state, counters and reset outputs; a release attempt is resolved after the case
  always_comb begin
    state_n = state;
    por_n   = por_cnt;
    gap_n   = gap;
    hcnt_n  = hcnt;
    k_n     = k;
    out_n   = out_r;
    rel     = 1'b0;
    rel_k   = k;
    case (state)
      S_RST: state_n = rst_s ? S_POR : S_RST;
      S_POR: begin
        por_n = por_cnt + 1'b1;
        rel   = por_n[CNT_W-1];
        rel_k = '0;
      end
      S_REL: begin
        gap_n = gap + 1'b1;
        rel   = gap == GAP_W'(STAGE_GAP - 1);
      end
      S_LINK: begin
        state_n = link_s ? S_REL : S_LINK;
        gap_n   = link_s ? GAP_W'(STAGE_GAP - 1) : gap;
      end
      S_RUN: begin
        if (press || soft_rst) begin
          state_n = S_HOLD;
          out_n   = '0;
          hcnt_n  = '0;
        end else if (LINK_DOM < NUM_DOM && !link_s) begin
          state_n = S_LINK;
          out_n   = out_r & LOW_MASK;
          k_n     = K_W'(LINK_DOM);
        end
      end
      S_HOLD: begin
        hcnt_n = hcnt + 1'b1;
        rel    = hcnt == H_W'(HOLD_CYC - 1);
        rel_k  = '0;
      end
      default: state_n = S_RST;
    endcase
    if (rel) begin
      if (32'(rel_k) >= LINK_DOM && !link_s) begin
        state_n = S_LINK;
        k_n     = rel_k;
      end else begin
        out_n[rel_k] = 1'b1;
        gap_n        = '0;
        state_n      = 32'(rel_k) == NUM_DOM - 1 ? S_RUN : S_REL;
        k_n          = 32'(rel_k) == NUM_DOM - 1 ? rel_k : rel_k + 1'b1;
      end
    end
  end

  // state and counter registers; rstn clears everything immediately, including the outputs
  always_ff @(posedge clk_125 or negedge rstn)
    if (!rstn) begin
      state   <= S_RST;
      por_cnt <= '0;
      gap     <= '0;
      hcnt    <= '0;
      k       <= '0;
      out_r   <= '0;
    end else begin
      state   <= state_n;
      por_cnt <= por_n;
      gap     <= gap_n;
      hcnt    <= hcnt_n;
      k       <= k_n;
      out_r   <= out_n;
    end

  assign rst_n_out = out_r;
  assign seq_done  = state == S_RUN;
  assign seq_state = state;
endmodule

// File: tb/tb_pcie_rst_seq.sv
// tb_pcie_rst_seq: directed checks of POR timing, link gating, soft/button reset, link drop and async reset
module tb_pcie_rst_seq;
  import pcie_rst_pkg::*;
  logic clk_125 = 1'b0;
  logic rstn = 1'b0;
  logic btn_n = 1'b1;
  logic soft_rst = 1'b0;
  logic link_up = 1'b1;
  logic [2:0] rst_n_out;
  logic seq_done;
  logic [2:0] seq_state;
  int n_chk = 0;
  int n_pass = 0;
  int found;

  pcie_rst_seq #(
    .NUM_DOM(3), .CNT_W(5), .STAGE_GAP(4), .DEB_W(3), .LINK_DOM(1), .HOLD_CYC(8)
  ) dut (
    .clk_125(clk_125),
    .rstn(rstn),
    .btn_n(btn_n),
    .soft_rst(soft_rst),
    .link_up(link_up),
    .rst_n_out(rst_n_out),
    .seq_done(seq_done),
    .seq_state(seq_state)
  );

  always #4 clk_125 = ~clk_125;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_125);
    #1;
  endtask

  // called right after rstn is driven high; next edge is t=0
  task automatic por_seq(input string tag);
    step(2);
    chk({tag, "_rst_t1"}, seq_state, S_RST);
    step(1);
    chk({tag, "_por_t2"}, seq_state, S_POR);
    step(15);
    chk({tag, "_out_t17"}, rst_n_out, 3'b000);
    step(1);
    chk({tag, "_out_t18"}, rst_n_out, 3'b001);
    chk({tag, "_rel_t18"}, seq_state, S_REL);
    step(3);
    chk({tag, "_out_t21"}, rst_n_out, 3'b001);
    step(1);
    chk({tag, "_out_t22"}, rst_n_out, 3'b011);
    step(3);
    chk({tag, "_done_t25"}, seq_done, 1'b0);
    step(1);
    chk({tag, "_out_t26"}, rst_n_out, 3'b111);
    chk({tag, "_done_t26"}, seq_done, 1'b1);
    chk({tag, "_run_t26"}, seq_state, S_RUN);
  endtask

  // called just after the edge where all outputs first dropped
  task automatic hold_rel(input string tag);
    chk({tag, "_hold_h0"}, rst_n_out, 3'b000);
    chk({tag, "_state_h0"}, seq_state, S_HOLD);
    chk({tag, "_done_h0"}, seq_done, 1'b0);
    step(7);
    chk({tag, "_hold_h7"}, rst_n_out, 3'b000);
    step(1);
    chk({tag, "_out_h8"}, rst_n_out, 3'b001);
    step(3);
    chk({tag, "_out_h11"}, rst_n_out, 3'b001);
    step(1);
    chk({tag, "_out_h12"}, rst_n_out, 3'b011);
    step(4);
    chk({tag, "_out_h16"}, rst_n_out, 3'b111);
    chk({tag, "_done_h16"}, seq_done, 1'b1);
  endtask

  initial begin
    step(3);
    chk("reset_out", rst_n_out, 3'b000);
    chk("reset_done", seq_done, 1'b0);
    chk("reset_state", seq_state, S_RST);
    rstn = 1'b1;
    por_seq("t1");

    step(2);
    soft_rst = 1'b1;
    step(1);
    soft_rst = 1'b0;
    hold_rel("t3");

    step(2);
    for (int i = 0; i < 5; i++) begin
      btn_n = 1'b0;
      step(3);
      btn_n = 1'b1;
      step(1);
    end
    step(3);
    chk("t4_bounce_out", rst_n_out, 3'b111);
    chk("t4_bounce_state", seq_state, S_RUN);
    btn_n = 1'b0;
    step(8);
    chk("t4_before_press", rst_n_out, 3'b111);
    found = 0;
    for (int i = 0; i < 5 && found == 0; i++) begin
      step(1);
      found = (rst_n_out == 3'b000) ? 1 : 0;
    end
    chk("t4_press_seen", found, 1);
    if (found == 1) hold_rel("t4");
    step(30);
    chk("t4_no_repress_out", rst_n_out, 3'b111);
    chk("t4_no_repress_state", seq_state, S_RUN);
    btn_n = 1'b1;
    step(3);

    link_up = 1'b0;
    step(3);
    chk("t5_drop_out", rst_n_out, 3'b001);
    chk("t5_drop_done", seq_done, 1'b0);
    chk("t5_drop_state", seq_state, S_LINK);
    step(2);
    link_up = 1'b1;
    step(3);
    chk("t5_back_state", seq_state, S_REL);
    chk("t5_back_out0", rst_n_out, 3'b001);
    step(1);
    chk("t5_back_out1", rst_n_out, 3'b011);
    step(4);
    chk("t5_back_out2", rst_n_out, 3'b111);
    chk("t5_back_done", seq_done, 1'b1);

    step(1);
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
    step(20);
    chk("t6_mid_out", rst_n_out, 3'b001);
    rstn = 1'b0;
    #1;
    chk("t6_async_out", rst_n_out, 3'b000);
    chk("t6_async_done", seq_done, 1'b0);
    chk("t6_async_state", seq_state, S_RST);
    step(2);
    rstn = 1'b1;
    por_seq("t6");

    step(1);
    rstn = 1'b0;
    link_up = 1'b0;
    step(2);
    rstn = 1'b1;
    step(19);
    chk("t2_out_t18", rst_n_out, 3'b001);
    step(4);
    chk("t2_out_t22", rst_n_out, 3'b001);
    chk("t2_link_t22", seq_state, S_LINK);
    step(8);
    soft_rst = 1'b1;
    step(1);
    soft_rst = 1'b0;
    chk("t2_soft_ignored", seq_state, S_LINK);
    chk("t2_soft_out", rst_n_out, 3'b001);
    step(8);
    link_up = 1'b1;
    step(3);
    chk("t2_out_t42", rst_n_out, 3'b001);
    step(1);
    chk("t2_out_t43", rst_n_out, 3'b011);
    step(3);
    chk("t2_out_t46", rst_n_out, 3'b011);
    step(1);
    chk("t2_out_t47", rst_n_out, 3'b111);
    chk("t2_done_t47", seq_done, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
